saturn_jump_decoder: RTL and testbench

Sub-decoder for the unconditional jump and return opcodes: GOTO, GOSUB, GOLONG, GOSUBL, GOVLNG, GOSBVL, and RTN/RTNSXM/RTNSC/RTNCC.
- Sits directly upstream of the PC/RSTK stage and watches the same fetched nibble stream.
- Produces that stage's jump, push and return controls with the phase alignment it expects: start on phase 3, consume on phase 2.
- Opcodes it does not own are flagged back to the main decoder.

---
 rtl/saturn_jump_decoder_pkg.sv | 49 ++++
 rtl/saturn_jump_decoder_if.sv | 38 +++
 rtl/saturn_jump_decoder.sv | 132 +++++++++++++
 tb/tb_saturn_jump_decoder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/saturn_jump_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : saturn_jump_decoder_pkg
// Purpose  : Shared opcode nibbles, jump length codes, return kinds and
//            state encoding for the jump/return sub-decoder.
// Revision : 1.0 - initial release
// ============================================================================
package saturn_jump_decoder_pkg;

  // First-nibble opcodes owned by this decoder
  localparam logic [3:0] OP_0X      = 4'h0;
  localparam logic [3:0] OP_GOTO    = 4'h6;
  localparam logic [3:0] OP_GOSUB   = 4'h7;
  localparam logic [3:0] OP_8X      = 4'h8;

  // Second nibbles of the 8x long-jump group.
  // Bit 0 selects absolute (D/F) over relative (C/E); bit 1 selects push (E/F).
  localparam logic [3:0] SUB_GOLONG = 4'hC;
  localparam logic [3:0] SUB_GOVLNG = 4'hD;
  localparam logic [3:0] SUB_GOSUBL = 4'hE;
  localparam logic [3:0] SUB_GOSBVL = 4'hF;

  // Jump length codes; the number of offset nibbles is code + 1
  localparam logic [2:0] JL_NONE    = 3'd0;
  localparam logic [2:0] JL_REL2    = 3'd1;
  localparam logic [2:0] JL_REL3    = 3'd2;
  localparam logic [2:0] JL_REL4    = 3'd3;
  localparam logic [2:0] JL_ABS5    = 3'd4;

  // Return kinds, taken from the low two bits of the RTN second nibble
  localparam logic [1:0] RK_SXM     = 2'd0;
  localparam logic [1:0] RK_PLAIN   = 2'd1;
  localparam logic [1:0] RK_SC      = 2'd2;
  localparam logic [1:0] RK_CC      = 2'd3;

  // One-hot phase strobe patterns the decoder acts on
  localparam logic [3:0] PH_2       = 4'b0100;
  localparam logic [3:0] PH_3       = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BLK0   = 3'd1,
    ST_BLK8   = 3'd2,
    ST_OFFSET = 3'd3,
    ST_RTN    = 3'd4
  } state_t;

endpackage : saturn_jump_decoder_pkg
`default_nettype wire

// File: rtl/saturn_jump_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : saturn_jump_decoder_if
// Purpose  : Fetch-side inputs and PC/RSTK-side controls of the jump decoder.
//            slave = the decoder, master = the fetch / PC stage driving it.
// Revision : 1.0 - initial release
// ============================================================================
interface saturn_jump_decoder_if;
  logic       i_clk_en;
  logic [3:0] i_phases;
  logic       i_bus_busy;
  logic       i_exec_unit_busy;
  logic       i_instr_start;
  logic [3:0] i_nibble;

  logic       o_jump_instr;
  logic [2:0] o_jump_length;
  logic       o_push_pc;
  logic       o_block_0x;
  logic       o_rtn_instr;
  logic [1:0] o_rtn_kind;
  logic       o_busy;
  logic       o_done;
  logic       o_not_mine;

  modport slave (
    input  i_clk_en, i_phases, i_bus_busy, i_exec_unit_busy, i_instr_start, i_nibble,
    output o_jump_instr, o_jump_length, o_push_pc, o_block_0x, o_rtn_instr,
           o_rtn_kind, o_busy, o_done, o_not_mine
  );

  modport master (
    output i_clk_en, i_phases, i_bus_busy, i_exec_unit_busy, i_instr_start, i_nibble,
    input  o_jump_instr, o_jump_length, o_push_pc, o_block_0x, o_rtn_instr,
           o_rtn_kind, o_busy, o_done, o_not_mine
  );
endinterface : saturn_jump_decoder_if
`default_nettype wire

// File: rtl/saturn_jump_decoder.sv
`default_nettype none
// ============================================================================
// Module   : saturn_jump_decoder
// Purpose  : Decodes GOTO/GOSUB/GOLONG/GOSUBL/GOVLNG/GOSBVL and the RTN group
//            from the fetched nibble stream, driving PC/RSTK jump, push and
//            return controls. Foreign opcodes are flagged with o_not_mine.
// Revision : 1.0 - initial release
// ============================================================================
module saturn_jump_decoder
  import saturn_jump_decoder_pkg::*;
(
  input  wire logic            i_clk,
  input  wire logic            i_reset,
  saturn_jump_decoder_if.slave bus
);

  state_t     r_state;
  logic [2:0] r_ctr;     // offset nibbles consumed so far

  logic w_gated;         // edge on which the block is allowed to advance
  logic w_ph2;
  logic w_ph3;

  assign w_gated = bus.i_clk_en && !bus.i_bus_busy && !bus.i_exec_unit_busy;
  assign w_ph2   = (bus.i_phases == PH_2);
  assign w_ph3   = (bus.i_phases == PH_3);

  // Decoder FSM with registered controls; pulses last exactly one gated cycle
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state           <= ST_IDLE;
      r_ctr             <= 3'd0;
      bus.o_jump_instr  <= 1'b0;
      bus.o_jump_length <= JL_NONE;
      bus.o_push_pc     <= 1'b0;
      bus.o_block_0x    <= 1'b0;
      bus.o_rtn_instr   <= 1'b0;
      bus.o_rtn_kind    <= RK_SXM;
      bus.o_busy        <= 1'b0;
      bus.o_done        <= 1'b0;
      bus.o_not_mine    <= 1'b0;
    end else if (w_gated) begin
      bus.o_done     <= 1'b0;
      bus.o_not_mine <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ph2 && bus.i_instr_start) begin
            case (bus.i_nibble)
              OP_0X: begin
                r_state        <= ST_BLK0;
                bus.o_block_0x <= 1'b1;
                bus.o_busy     <= 1'b1;
              end
              OP_GOTO, OP_GOSUB: begin
                r_state           <= ST_OFFSET;
                r_ctr             <= 3'd0;
                bus.o_jump_instr  <= 1'b1;
                bus.o_jump_length <= JL_REL3;
                bus.o_push_pc     <= (bus.i_nibble == OP_GOSUB);
                bus.o_busy        <= 1'b1;
              end
              OP_8X: begin
                r_state    <= ST_BLK8;
                bus.o_busy <= 1'b1;
              end
              default: bus.o_not_mine <= 1'b1;
            endcase
          end
        end
        ST_BLK8: begin
          if (w_ph2) begin
            case (bus.i_nibble)
              SUB_GOLONG, SUB_GOVLNG, SUB_GOSUBL, SUB_GOSBVL: begin
                r_state           <= ST_OFFSET;
                r_ctr             <= 3'd0;
                bus.o_jump_instr  <= 1'b1;
                bus.o_jump_length <= bus.i_nibble[0] ? JL_ABS5 : JL_REL4;
                bus.o_push_pc     <= bus.i_nibble[1];
              end
              default: begin
                r_state        <= ST_IDLE;
                bus.o_not_mine <= 1'b1;
                bus.o_busy     <= 1'b0;
              end
            endcase
          end
        end
        ST_OFFSET: begin
          // The final offset nibble is the one consumed while ctr == length
          if (w_ph2) begin
            if (r_ctr == bus.o_jump_length) begin
              r_state           <= ST_IDLE;
              r_ctr             <= 3'd0;
              bus.o_jump_instr  <= 1'b0;
              bus.o_jump_length <= JL_NONE;
              bus.o_push_pc     <= 1'b0;
              bus.o_busy        <= 1'b0;
              bus.o_done        <= 1'b1;
            end else begin
              r_ctr <= r_ctr + 3'd1;
            end
          end
        end
        ST_BLK0: begin
          if (w_ph2) begin
            bus.o_block_0x <= 1'b0;
            if (bus.i_nibble[3:2] == 2'b00) begin
              r_state         <= ST_RTN;
              bus.o_rtn_kind  <= bus.i_nibble[1:0];
              bus.o_rtn_instr <= 1'b1;
            end else begin
              r_state        <= ST_IDLE;
              bus.o_not_mine <= 1'b1;
              bus.o_busy     <= 1'b0;
            end
          end
        end
        ST_RTN: begin
          if (w_ph3) begin
            r_state         <= ST_IDLE;
            bus.o_rtn_instr <= 1'b0;
            bus.o_busy      <= 1'b0;
            bus.o_done      <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule : saturn_jump_decoder
`default_nettype wire

// File: tb/tb_saturn_jump_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_saturn_jump_decoder
// Purpose  : Self-checking bench for saturn_jump_decoder. One nibble slot is
//            four clocks (phases 0..3); expected outputs for every cycle of an
//            instruction come from a timeline model derived from the opcode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_saturn_jump_decoder;
  import saturn_jump_decoder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  saturn_jump_decoder_if bus();

  saturn_jump_decoder dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // Observed / expected output vectors per timeline cycle t = 4*slot + phase
  logic [11:0] obs_v [64];
  logic [11:0] exp_v [64];
  int          stall_t_q [$];
  logic [11:0] stall_v_q [$];
  logic [19:0] cons_off;      // offset assembled by a PC/RSTK-like consumer
  int          cons_cnt;
  logic [1:0]  model_kind;    // return kind the decoder should be holding
  int          stall_pct;
  int          force_stall_t;
  int          force_stall_n;

  // {jump, length[2:0], push, block_0x, rtn, kind[1:0], busy, done, not_mine}
  function automatic logic [11:0] pack_out();
    return {bus.o_jump_instr, bus.o_jump_length, bus.o_push_pc, bus.o_block_0x,
            bus.o_rtn_instr, bus.o_rtn_kind, bus.o_busy, bus.o_done, bus.o_not_mine};
  endfunction

  // Timeline model: classify the instruction, then derive every cycle's outputs
  task automatic model_instr(input logic [3:0] nb [8], output int ncyc, output int nslot,
                             output logic [19:0] eoff, output int ecnt);
    int cat, l1, len, m, a, b;
    logic push, blk0;
    logic jmp, rtnv, busyv, donev, nmv, blkv;
    logic [1:0] kindv;
    cat = 2; l1 = 0; len = 0; m = 0; push = 1'b0; blk0 = 1'b0;
    if (nb[0] == 4'h6 || nb[0] == 4'h7) begin
      cat = 0; l1 = 1; len = 2; push = (nb[0] == 4'h7);
    end else if (nb[0] == 4'h8) begin
      if (nb[1] >= 4'hC) begin
        cat = 0; l1 = 2;
        len = (nb[1] == 4'hD || nb[1] == 4'hF) ? 4 : 3;
        push = (nb[1] == 4'hE || nb[1] == 4'hF);
      end else m = 1;
    end else if (nb[0] == 4'h0) begin
      blk0 = 1'b1;
      if (nb[1] < 4'h4) cat = 1; else m = 1;
    end
    nslot = (cat == 0) ? l1 + len + 1 : (cat == 1) ? 2 : m + 1;
    ncyc  = 4 * (nslot + 1);
    a = 4 * (l1 - 1) + 3;
    b = 4 * (nslot - 1) + 3;
    eoff = 20'h0; ecnt = 0;
    if (cat == 0) begin
      ecnt = len + 1;
      for (int k = 0; k < ecnt; k++) eoff = eoff | (20'(nb[l1 + k]) << (4 * k));
    end
    for (int t = 0; t < ncyc; t++) begin
      jmp = 1'b0; rtnv = 1'b0; busyv = 1'b0; donev = 1'b0; nmv = 1'b0; blkv = 1'b0;
      kindv = model_kind;
      if (cat == 0) begin
        jmp = (t >= a && t < b); busyv = (t >= 3 && t < b); donev = (t == b);
      end else if (cat == 1) begin
        blkv = (t >= 3 && t < 7); rtnv = (t == 7); busyv = (t >= 3 && t < 8);
        donev = (t == 8);
        if (t >= 7) kindv = nb[1][1:0];
      end else begin
        busyv = (m == 1 && t >= 3 && t < 7); blkv = blk0 && busyv; nmv = (t == 4 * m + 3);
      end
      exp_v[t] = {jmp, jmp ? 3'(len) : 3'd0, jmp & push, blkv, rtnv, kindv, busyv, donev, nmv};
    end
    if (cat == 1) model_kind = nb[1][1:0];
  endtask

  // Drive one instruction slot by slot, inserting stalls, and capture outputs
  task automatic run_instr(input logic [3:0] nb [8], input int ncyc, input int nslot,
                           input int stop_t);
    int j, p, n, k;
    cons_off = 20'h0; cons_cnt = 0;
    stall_t_q.delete(); stall_v_q.delete();
    for (int t = 0; t < ncyc; t++) begin
      j = t / 4; p = t % 4;
      bus.i_phases      = 4'b0001 << p;
      bus.i_nibble      = (j < nslot) ? nb[j] : 4'($urandom);
      bus.i_instr_start = (j == 0) ? 1'b1 : (j < nslot) ? 1'($urandom_range(0, 1)) : 1'b0;
      n = (t == force_stall_t) ? force_stall_n :
          (int'($urandom_range(0, 99)) < stall_pct) ? int'($urandom_range(1, 3)) : 0;
      for (int s = 0; s < n; s++) begin
        k = (t == force_stall_t) ? 1 : int'($urandom_range(0, 2));
        bus.i_clk_en         = (k != 0);
        bus.i_bus_busy       = (k == 1);
        bus.i_exec_unit_busy = (k == 2);
        @(negedge clk);
        stall_t_q.push_back(t);
        stall_v_q.push_back(pack_out());
        @(posedge clk); #1;
      end
      bus.i_clk_en = 1'b1; bus.i_bus_busy = 1'b0; bus.i_exec_unit_busy = 1'b0;
      @(negedge clk);
      obs_v[t] = pack_out();
      if (p == 2 && bus.o_jump_instr && cons_cnt < 5) begin
        cons_off = cons_off | (20'(bus.i_nibble) << (4 * cons_cnt));
        cons_cnt++;
      end
      @(posedge clk); #1;
      if (t == stop_t) return;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_clk_en = 1'b1; bus.i_bus_busy = 1'b0; bus.i_exec_unit_busy = 1'b0;
    bus.i_phases = 4'b0100; bus.i_instr_start = 1'b1; bus.i_nibble = 4'h6;
    model_kind = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (pack_out() !== 12'h000) begin
      bad++; $display("FAIL reset_state got=%03h want=000", pack_out());
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_goto();
    logic [3:0] nb [8]; int nc, ns, ec; logic [19:0] eo;
    nb = '{4'h6, 4'h3, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    stall_pct = 0; force_stall_t = -1;
    model_instr(nb, nc, ns, eo, ec);
    run_instr(nb, nc, ns, -1);
    for (int t = 0; t < nc; t++) begin
      total++;
      if (obs_v[t] !== exp_v[t]) begin bad++; $display("FAIL goto_trace t=%0d got=%03h want=%03h", t, obs_v[t], exp_v[t]); end
    end
    total++;
    if (obs_v[3] !== 12'b1_010_0_0_0_00_1_0_0) begin bad++; $display("FAIL goto_first_jump got=%03h want=%03h", obs_v[3], 12'b1_010_0_0_0_00_1_0_0); end
    total++;
    if (cons_off !== 20'h00123 || cons_cnt != 3) begin bad++; $display("FAIL goto_offset got=%05h/%0d want=00123/3", cons_off, cons_cnt); end
  endtask

  task automatic test_gosbvl();
    logic [3:0] nb [8]; int nc, ns, ec; logic [19:0] eo;
    nb = '{4'h8, 4'hF, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0};
    stall_pct = 0; force_stall_t = -1;
    model_instr(nb, nc, ns, eo, ec);
    run_instr(nb, nc, ns, -1);
    for (int t = 0; t < nc; t++) begin
      total++;
      if (obs_v[t] !== exp_v[t]) begin bad++; $display("FAIL gosbvl_trace t=%0d got=%03h want=%03h", t, obs_v[t], exp_v[t]); end
    end
    total++;
    if (obs_v[26][11:7] !== 5'b1_100_1) begin bad++; $display("FAIL gosbvl_last_nibble got=%02h want=19", obs_v[26][11:7]); end
    total++;
    if (cons_off !== 20'h12345 || cons_cnt != 5) begin bad++; $display("FAIL gosbvl_offset got=%05h/%0d want=12345/5", cons_off, cons_cnt); end
  endtask

  task automatic test_rtn();
    logic [3:0] nb [8]; int nc, ns, ec; logic [19:0] eo;
    stall_pct = 0; force_stall_t = -1;
    for (int r = 0; r < 2; r++) begin
      nb = '{4'h0, (r == 0) ? 4'h1 : 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      model_instr(nb, nc, ns, eo, ec);
      run_instr(nb, nc, ns, -1);
      for (int t = 0; t < nc; t++) begin
        total++;
        if (obs_v[t] !== exp_v[t]) begin bad++; $display("FAIL rtn%0d_trace t=%0d got=%03h want=%03h", r, t, obs_v[t], exp_v[t]); end
      end
      total++;
      if (obs_v[6][6] !== 1'b1 || obs_v[7][5] !== 1'b1 || obs_v[7][4:3] !== ((r == 0) ? 2'd1 : 2'd3)) begin
        bad++; $display("FAIL rtn%0d_points got=%03h/%03h want blk0@6 rtn+kind=%0d@7", r, obs_v[6], obs_v[7], (r == 0) ? 1 : 3);
      end
    end
  endtask

  task automatic test_not_mine();
    logic [3:0] nb [8]; int nc, ns, ec; logic [19:0] eo;
    logic [3:0] firsts [3]; logic [3:0] seconds [3]; int at [3];
    firsts = '{4'h0, 4'h8, 4'h2}; seconds = '{4'h5, 4'hA, 4'h6}; at = '{7, 7, 3};
    stall_pct = 0; force_stall_t = -1;
    for (int c = 0; c < 3; c++) begin
      nb = '{firsts[c], seconds[c], 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
      model_instr(nb, nc, ns, eo, ec);
      run_instr(nb, nc, ns, -1);
      for (int t = 0; t < nc; t++) begin
        total++;
        if (obs_v[t] !== exp_v[t]) begin bad++; $display("FAIL notmine%0d_trace t=%0d got=%03h want=%03h", c, t, obs_v[t], exp_v[t]); end
      end
      total++;
      if (obs_v[at[c]][0] !== 1'b1 || cons_cnt != 0) begin bad++; $display("FAIL notmine%0d_flag got=%03h jumps=%0d want flag@%0d jumps=0", c, obs_v[at[c]], cons_cnt, at[c]); end
    end
  endtask

  task automatic test_stall();
    logic [3:0] nb [8]; int nc, ns, ec; logic [19:0] eo;
    nb = '{4'h6, 4'h3, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    stall_pct = 0; force_stall_t = 11; force_stall_n = 5;
    model_instr(nb, nc, ns, eo, ec);
    run_instr(nb, nc, ns, -1);
    force_stall_t = -1;
    total++;
    if (stall_v_q.size() != 5) begin bad++; $display("FAIL stall_count got=%0d want=5", stall_v_q.size()); end
    foreach (stall_v_q[i]) begin
      total++;
      if (stall_v_q[i] !== exp_v[stall_t_q[i]]) begin bad++; $display("FAIL stall_hold i=%0d got=%03h want=%03h", i, stall_v_q[i], exp_v[stall_t_q[i]]); end
    end
    for (int t = 0; t < nc; t++) begin
      total++;
      if (obs_v[t] !== exp_v[t]) begin bad++; $display("FAIL stall_trace t=%0d got=%03h want=%03h", t, obs_v[t], exp_v[t]); end
    end
    total++;
    if (cons_off !== 20'h00123 || cons_cnt != 3) begin bad++; $display("FAIL stall_offset got=%05h/%0d want=00123/3", cons_off, cons_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] nb [8]; int nc, ns, ec; logic [19:0] eo;
    nb = '{4'h8, 4'hE, 4'h9, 4'h7, 4'h5, 4'h3, 4'h0, 4'h0};
    stall_pct = 0; force_stall_t = -1;
    model_instr(nb, nc, ns, eo, ec);
    run_instr(nb, nc, ns, 10);
    for (int t = 0; t <= 10; t++) begin
      total++;
      if (obs_v[t] !== exp_v[t]) begin bad++; $display("FAIL rstmid_trace t=%0d got=%03h want=%03h", t, obs_v[t], exp_v[t]); end
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (pack_out() !== 12'h000) begin bad++; $display("FAIL rstmid_async got=%03h want=000", pack_out()); end
    model_kind = 2'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    nb = '{4'h6, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    model_instr(nb, nc, ns, eo, ec);
    run_instr(nb, nc, ns, -1);
    for (int t = 0; t < nc; t++) begin
      total++;
      if (obs_v[t] !== exp_v[t]) begin bad++; $display("FAIL rstmid_goto t=%0d got=%03h want=%03h", t, obs_v[t], exp_v[t]); end
    end
    total++;
    if (obs_v[3][10:8] !== 3'd2 || cons_cnt != 3) begin bad++; $display("FAIL rstmid_len got=%0d/%0d want=2/3", obs_v[3][10:8], cons_cnt); end
  endtask

  task automatic test_random();
    logic [3:0] nb [8]; int nc, ns, ec, cat, v; logic [19:0] eo;
    stall_pct = 15; force_stall_t = -1;
    for (int n = 0; n < 60; n++) begin
      foreach (nb[i]) nb[i] = 4'($urandom);
      cat = int'($urandom_range(0, 5));
      case (cat)
        0: nb[0] = 4'($urandom_range(6, 7));
        1: begin nb[0] = 4'h8; nb[1] = 4'($urandom_range(12, 15)); end
        2: begin nb[0] = 4'h8; nb[1] = 4'($urandom_range(0, 11)); end
        3: begin nb[0] = 4'h0; nb[1] = 4'($urandom_range(0, 3)); end
        4: begin nb[0] = 4'h0; nb[1] = 4'($urandom_range(4, 15)); end
        default: begin v = int'($urandom_range(1, 12)); nb[0] = 4'((v <= 5) ? v : v + 3); end
      endcase
      model_instr(nb, nc, ns, eo, ec);
      run_instr(nb, nc, ns, -1);
      for (int t = 0; t < nc; t++) begin
        total++;
        if (obs_v[t] !== exp_v[t]) begin bad++; $display("FAIL rand%0d_trace op=%h%h t=%0d got=%03h want=%03h", n, nb[0], nb[1], t, obs_v[t], exp_v[t]); end
      end
      foreach (stall_v_q[i]) begin
        total++;
        if (stall_v_q[i] !== exp_v[stall_t_q[i]]) begin bad++; $display("FAIL rand%0d_stall t=%0d got=%03h want=%03h", n, stall_t_q[i], stall_v_q[i], exp_v[stall_t_q[i]]); end
      end
      total++;
      if (cons_off !== eo || cons_cnt != ec) begin bad++; $display("FAIL rand%0d_offset got=%05h/%0d want=%05h/%0d", n, cons_off, cons_cnt, eo, ec); end
    end
  endtask

  initial begin
    force_stall_t = -1; force_stall_n = 0; stall_pct = 0;
    test_reset();
    test_goto();
    test_gosbvl();
    test_rtn();
    test_not_mine();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_saturn_jump_decoder
`default_nettype wire
